// File: rtl/fifo_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ser_pkg
// Shared types and sizing helpers for the FIFO drain serializer.
//   state_t     : serializer FSM states (IDLE, SEND, ERR)
//   calcNchunk  : number of OUT_W chunks that make up one DATA_W word
//   calcCntW    : width of the chunk counter (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package fifo_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ERR  = 2'd2
  } state_t;

  function automatic int calcNchunk(input int dataW, input int outW);
    return dataW / outW;
  endfunction

  // A single-chunk word still needs a 1-bit counter so the compare logic
  // has something to look at.
  function automatic int calcCntW(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/fifo_serializer_shift_reg.sv
// -----------------------------------------------------------------------------
// ser_shift_reg
// Holds the word currently being serialized and presents its next chunk.
// Build option: SER_MSB_FIRST_EN defined -> chunks leave MSB first and the
// register shifts left; undefined -> chunks leave LSB first, shifting right.
// Ports:
//   clk      in  clock, rising edge
//   rst_n    in  asynchronous active-low reset (clears the register)
//   i_load   in  capture i_data (takes priority over i_shift)
//   i_shift  in  advance to the next chunk
//   i_data   in  DATA_W word to capture
//   o_chunk  out OUT_W chunk currently at the output end of the register
// -----------------------------------------------------------------------------
module ser_shift_reg #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic [OUT_W-1:0]  o_chunk
);

  logic [DATA_W-1:0] r_shreg;

  // Load wins over shift so a back-to-back reload on the last accept
  // replaces the finished word instead of shifting it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
`ifdef SER_MSB_FIRST_EN
      r_shreg <= r_shreg << OUT_W;
`else
      r_shreg <= r_shreg >> OUT_W;
`endif
    end
  end

`ifdef SER_MSB_FIRST_EN
  assign o_chunk = r_shreg[DATA_W-1 -: OUT_W];
`else
  assign o_chunk = r_shreg[OUT_W-1:0];
`endif

endmodule

// File: rtl/fifo_serializer.sv
// -----------------------------------------------------------------------------
// fifo_serializer
// Drain stage for the 4-entry FIFO controller: pops head words, emits each as
// DATA_W/OUT_W chunks over valid/ready with a last-chunk marker, latches the
// controller's error flag as a sticky fault and counts completed words.
// Build option: SER_MSB_FIRST_EN (see ser_shift_reg) selects MSB-first chunk
// order; handshake, counting and latency are the same either way.
// Ports:
//   clk         in  clock, rising edge
//   rst_n       in  asynchronous active-low reset
//   fifo_empty  in  FIFO has no entries
//   fifo_err    in  FIFO controller illegal-state flag
//   fifo_data   in  FIFO head word, valid while fifo_empty=0
//   pop_fifo    out combinational pop strobe, one cycle per word
//   out_data    out current chunk
//   out_valid   out chunk valid
//   out_ready   in  downstream accepts chunk
//   out_last    out final chunk of the current word
//   busy        out a word is held (SEND)
//   err         out sticky fault
//   word_count  out words fully emitted, wraps
// -----------------------------------------------------------------------------
module fifo_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic              fifo_err,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              pop_fifo,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);

  localparam int NCHUNK = calcNchunk(DATA_W, OUT_W);
  localparam int CCW    = calcCntW(NCHUNK);
  localparam logic [CCW-1:0] LAST_IDX = CCW'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [CCW-1:0]   r_chunkCnt;
  logic [CNT_W-1:0] r_wordCount;
  logic             r_err;

  logic             w_pop;
  logic             w_load;
  logic             w_shift;
  logic             w_wordDone;
  logic             w_accept;
  logic             w_isLast;
  logic [OUT_W-1:0] w_chunk;

  ser_shift_reg #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (fifo_data),
    .o_chunk (w_chunk)
  );

  assign w_accept = (r_state == SEND) && out_ready;
  assign w_isLast = (r_chunkCnt == LAST_IDX);

  // Next-state and control decode. fifo_err overrides everything: the held
  // word is abandoned, nothing is popped and the count is left alone.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_wordDone  = 1'b0;
    if (fifo_err) begin
      w_nextState = ERR;
    end else begin
      case (r_state)
        IDLE: begin
          if (!fifo_empty) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_nextState = SEND;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (w_isLast) begin
              w_wordDone = 1'b1;
              // Reloading on the last accept keeps back-to-back words
              // free of an idle bubble.
              if (!fifo_empty) begin
                w_pop  = 1'b1;
                w_load = 1'b1;
              end else begin
                w_nextState = IDLE;
              end
            end else begin
              w_shift = 1'b1;
            end
          end
        end
        ERR:     w_nextState = ERR;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chunkCnt  <= '0;
      r_wordCount <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_load) begin
        r_chunkCnt <= '0;
      end else if (w_shift) begin
        r_chunkCnt <= r_chunkCnt + 1'b1;
      end
      if (w_wordDone) begin
        r_wordCount <= r_wordCount + 1'b1;
      end
      r_err <= r_err | fifo_err;
    end
  end

  // The FSM sits in IDLE while reset is held, so the pop strobe is gated
  // with rst_n to keep the FIFO untouched during reset.
  assign pop_fifo   = w_pop & rst_n;
  assign busy       = (r_state == SEND);
  assign out_valid  = busy;
  assign out_data   = busy ? w_chunk : '0;
  assign out_last   = busy & w_isLast;
  assign err        = r_err;
  assign word_count = r_wordCount;

endmodule

// File: tb/tb_fifo_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_serializer
// Scoreboard bench for fifo_serializer (DATA_W=8, OUT_W=2, CNT_W=8).
// Stimulus pushes words into a small FIFO model and queues the expected
// chunks; a monitor pops and compares on every accepted chunk, and also
// checks pop legality and output stability during stalls.
// Chunk order follows SER_MSB_FIRST_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_fifo_serializer;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 2;
  localparam int CNT_W  = 8;
  localparam int NCHUNK = DATA_W / OUT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fifo_empty;
  logic              fifo_err;
  logic [DATA_W-1:0] fifo_data;
  logic              pop_fifo;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              err;
  logic [CNT_W-1:0]  word_count;

  int numChecks = 0;
  int numFails  = 0;
  int acceptCount = 0;
  int popCount = 0;

  logic [OUT_W:0] scbQ[$];

  logic [DATA_W-1:0] fifoMem[16];
  logic [3:0]        fifoHead = '0;
  logic [3:0]        fifoTail = '0;

  logic             stallPrev = 1'b0;
  logic [OUT_W-1:0] prevData  = '0;
  logic             prevLast  = 1'b0;

  fifo_serializer #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_err   (fifo_err),
    .fifo_data  (fifo_data),
    .pop_fifo   (pop_fifo),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // FIFO model: head advances on the clock edge where the DUT pops.
  assign fifo_empty = (fifoHead == fifoTail);
  assign fifo_data  = fifoMem[fifoHead];

  always @(posedge clk) begin
    if (pop_fifo) begin
      fifoHead <= fifoHead + 4'd1;
      popCount = popCount + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    numChecks = numChecks + 1;
    if (actual != expected) begin
      numFails = numFails + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] expChunk(input logic [DATA_W-1:0] w, input int idx);
    logic [DATA_W-1:0] t;
`ifdef SER_MSB_FIRST_EN
    t = w >> (OUT_W * (NCHUNK - 1 - idx));
`else
    t = w >> (OUT_W * idx);
`endif
    return t[OUT_W-1:0];
  endfunction

  task automatic pushExpected(input logic [DATA_W-1:0] w);
    for (int i = 0; i < NCHUNK; i++) begin
      scbQ.push_back({(i == NCHUNK - 1), expChunk(w, i)});
    end
  endtask

  task automatic pushFifo(input logic [DATA_W-1:0] w);
    fifoMem[fifoTail] = w;
    fifoTail = fifoTail + 4'd1;
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] w);
    pushFifo(w);
    pushExpected(w);
  endtask

  // Returns just after the clock edge that completes the target accept.
  task automatic waitAccepted(input int target);
    for (int c = 0; c < 60; c++) begin
      if (acceptCount >= target) begin
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      #1;
    end
    checkOutput("acceptTimeout", acceptCount, target);
  endtask

  // Monitor: scoreboard compare, pop legality, stall stability.
  always @(negedge clk) begin
    logic [OUT_W:0] exp;
    if (rst_n) begin
      if (pop_fifo) begin
        checkOutput("popWhileEmpty", fifo_empty, 0);
        checkOutput("popDuringErr", fifo_err, 0);
        checkOutput("popOnlyOnLastAccept", int'(!out_valid || (out_ready && out_last)), 1);
      end
      if (stallPrev && out_valid) begin
        checkOutput("stallDataHold", out_data, prevData);
        checkOutput("stallLastHold", out_last, prevLast);
      end
      if (out_valid && out_ready) begin
        if (scbQ.size() == 0) begin
          checkOutput("unexpectedChunk", 1, 0);
        end else begin
          exp = scbQ.pop_front();
          checkOutput("chunkData", out_data, exp[OUT_W-1:0]);
          checkOutput("chunkLast", out_last, exp[OUT_W]);
        end
        acceptCount = acceptCount + 1;
      end
      stallPrev = out_valid && !out_ready;
      prevData  = out_data;
      prevLast  = out_last;
    end else begin
      stallPrev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base;
    int pops;
    int runLen;

    rst_n     = 1'b0;
    fifo_err  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstPop", pop_fifo, 0);
    checkOutput("rstValid", out_valid, 0);
    checkOutput("rstLast", out_last, 0);
    checkOutput("rstData", out_data, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstCount", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word, one-cycle pop, first chunk the following cycle.
    @(negedge clk);
    #1;
    base = acceptCount;
    pops = popCount;
    applyStimulus(8'hB4);
    #1;
    checkOutput("t1PopNow", pop_fifo, 1);
    checkOutput("t1ValidNotYet", out_valid, 0);
    @(negedge clk);
    #1;
    checkOutput("t1ValidNext", out_valid, 1);
    checkOutput("t1NoSecondPop", pop_fifo, 0);
    checkOutput("t1FirstChunk", out_data, expChunk(8'hB4, 0));
    waitAccepted(base + 4);
    checkOutput("t1Count", word_count, 1);
    checkOutput("t1Idle", busy, 0);
    checkOutput("t1Pops", popCount - pops, 1);

    // Two queued words stream with no bubble.
    @(negedge clk);
    #1;
    pops = popCount;
    applyStimulus(8'hB4);
    applyStimulus(8'h1E);
    runLen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) runLen++;
      else if (runLen > 0) break;
    end
    checkOutput("t2Run", runLen, 8);
    checkOutput("t2Count", word_count, 3);
    checkOutput("t2Pops", popCount - pops, 2);

    // Stall three cycles on chunk 1.
    @(negedge clk);
    #1;
    base = acceptCount;
    applyStimulus(8'hB4);
    waitAccepted(base + 1);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checkOutput("t3HoldValid", out_valid, 1);
      checkOutput("t3HoldData", out_data, expChunk(8'hB4, 1));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitAccepted(base + 4);
    checkOutput("t3Count", word_count, 4);

    // fifo_err during chunk 2: word dropped, sticky fault.
    @(negedge clk);
    #1;
    base = acceptCount;
    applyStimulus(8'hB4);
    pushFifo(8'h1E);
    waitAccepted(base + 2);
    out_ready = 1'b0;
    fifo_err  = 1'b1;
    #1;
    checkOutput("t4PopForced0", pop_fifo, 0);
    @(posedge clk);
    #1;
    fifo_err  = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("t4Err", err, 1);
    checkOutput("t4Valid", out_valid, 0);
    checkOutput("t4Busy", busy, 0);
    checkOutput("t4Pop", pop_fifo, 0);
    checkOutput("t4Count", word_count, 4);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t4ErrSticky", err, 1);
    checkOutput("t4PopStill0", pop_fifo, 0);
    checkOutput("t4ValidStill0", out_valid, 0);
    scbQ.delete();

    // Reset clears the fault; the still-queued 0x1E is then drained.
    rst_n = 1'b0;
    #1;
    checkOutput("t4RstErr", err, 0);
    checkOutput("t4RstCount", word_count, 0);
    checkOutput("t4RstPop", pop_fifo, 0);
    @(negedge clk);
    base = acceptCount;
    pushExpected(8'h1E);
    rst_n = 1'b1;
    #1;
    checkOutput("t4FreshPop", pop_fifo, 1);
    waitAccepted(base + 4);
    checkOutput("t4PostCount", word_count, 1);

    // Reset in the middle of a word.
    @(negedge clk);
    #1;
    base = acceptCount;
    applyStimulus(8'hB4);
    waitAccepted(base + 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5Valid", out_valid, 0);
    checkOutput("t5Data", out_data, 0);
    checkOutput("t5Last", out_last, 0);
    checkOutput("t5Busy", busy, 0);
    checkOutput("t5Count", word_count, 0);
    scbQ.delete();
    pushFifo(8'h1E);
    #1;
    checkOutput("t5NoPopInReset", pop_fifo, 0);
    @(negedge clk);
    base = acceptCount;
    pushExpected(8'h1E);
    rst_n = 1'b1;
    #1;
    checkOutput("t5FreshPop", pop_fifo, 1);
    @(negedge clk);
    #1;
    checkOutput("t5Chunk0", out_data, expChunk(8'h1E, 0));
    waitAccepted(base + 4);
    checkOutput("t5PostCount", word_count, 1);
    checkOutput("t5Idle", busy, 0);

    repeat (2) @(negedge clk);
    checkOutput("scbDrained", scbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
